// File: rtl/spi_responder.sv
// SPI mode-0 responder: synchronizes the asynchronous SPI pins into the clk_i
// domain, shifts one byte per slot in each direction and keeps a single-entry
// TX holding buffer that the local side refills between byte slots.
module spi_responder #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       spi_sck_i,
    input  logic       spi_cs_i,
    input  logic       spi_mosi_i,
    output logic       spi_miso_o,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       busy_o,
    output logic       underrun_o,
    output logic       abort_o
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sck_d;
    logic                   cs_d;
    logic [SYNC_STAGES:0]   sync_vld;
    logic                   armed;

    logic       sck_s;
    logic       cs_s;
    logic       mosi_s;
    logic       sck_rise;
    logic       sck_fall;
    logic       cs_rise;
    logic       cs_fall;
    logic       slot_start;
    logic       tx_load;

    logic [0:0] state;
    logic [2:0] bit_cnt;
    logic [6:0] rx_sr;
    logic [7:0] tx_sr;
    logic [7:0] tx_buf;
    logic       buf_full;
    logic       byte_done;
    logic       rx_done;

    // Pin synchronizers plus one extra delayed copy of SCK/CS for edge detection.
    // The synchronizers reset to CS=1, so with CS held low across reset the chain
    // would show a fake CS fall; 'armed' only allows frame starts once CS has
    // been seen high through a fully refilled chain.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sck_d     <= 1'b0;
            cs_d      <= 1'b1;
            sync_vld  <= '0;
            armed     <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck_i};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_i};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
            sck_d     <= sck_sync[SYNC_STAGES-1];
            cs_d      <= cs_sync[SYNC_STAGES-1];
            sync_vld  <= {sync_vld[SYNC_STAGES-1:0], 1'b1};
            if (sync_vld[SYNC_STAGES] && cs_sync[SYNC_STAGES-1]) begin
                armed <= 1'b1;
            end
        end
    end

    // Edge detects, byte-slot start and buffer-load qualification.
    always_comb begin
        sck_s      = sck_sync[SYNC_STAGES-1];
        cs_s       = cs_sync[SYNC_STAGES-1];
        mosi_s     = mosi_sync[SYNC_STAGES-1];
        sck_rise   = sck_s & ~sck_d;
        sck_fall   = ~sck_s & sck_d;
        cs_rise    = cs_s & ~cs_d;
        cs_fall    = ~cs_s & cs_d & armed;
        slot_start = ((state == IDLE) && cs_fall) ||
                     ((state == SHIFT) && !cs_rise && sck_fall && byte_done);
        tx_load    = tx_valid_i && !buf_full;
    end

    // Frame FSM, shift registers, TX holding buffer and status pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            rx_sr      <= '0;
            tx_sr      <= '0;
            tx_buf     <= '0;
            buf_full   <= 1'b0;
            byte_done  <= 1'b0;
            rx_done    <= 1'b0;
            rx_data_o  <= '0;
            rx_valid_o <= 1'b0;
            underrun_o <= 1'b0;
            abort_o    <= 1'b0;
        end else begin
            rx_done    <= 1'b0;
            rx_valid_o <= rx_done;
            underrun_o <= 1'b0;
            abort_o    <= 1'b0;

            // A load can only happen into an empty buffer and a slot only
            // consumes a full one, so the two never collide; a load in the
            // slot-start cycle therefore waits for the following slot.
            if (tx_load) begin
                tx_buf   <= tx_data_i;
                buf_full <= 1'b1;
            end else if (slot_start && buf_full) begin
                buf_full <= 1'b0;
            end

            if (slot_start) begin
                byte_done <= 1'b0;
                if (buf_full) begin
                    tx_sr <= tx_buf;
                end else begin
                    tx_sr      <= 8'hFF;
                    underrun_o <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                        rx_sr   <= '0;
                    end
                end
                default: begin
                    if (cs_rise) begin
                        state     <= IDLE;
                        abort_o   <= (bit_cnt != 3'd0);
                        bit_cnt   <= '0;
                        rx_sr     <= '0;
                        byte_done <= 1'b0;
                    end else if (sck_rise) begin
                        rx_sr   <= {rx_sr[5:0], mosi_s};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_data_o <= {rx_sr, mosi_s};
                            rx_done   <= 1'b1;
                            byte_done <= 1'b1;
                        end
                    end else if (sck_fall && !byte_done) begin
                        tx_sr <= {tx_sr[6:0], 1'b1};
                    end
                end
            endcase
        end
    end

    assign spi_miso_o = (state == SHIFT) ? tx_sr[7] : 1'b1;
    assign tx_ready_o = ~buf_full;
    assign busy_o     = (state == SHIFT);

endmodule
